// File: rtl/sik_pkg.sv
// Shared definitions for the two-thread stack processor: opcodes, the idle
// instruction word, and the prefix-lock state encoding.
package sik_pkg;

  localparam int unsigned SIK_WIDTH = 16;

  localparam logic [3:0]  OP_PRE  = 4'hF;
  localparam logic [15:0] NOOP_IR = 16'h003F;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_0    = 2'd1,
    LK_1    = 2'd2
  } lock_t;

endpackage

// File: rtl/thread_sched_rr_pick2.sv
// Combinational 2-way round-robin picker; an active lock restricts the choice
// to the locked thread alone.
module rr_pick2
  import sik_pkg::*;
(
  input  logic [1:0] eligible,
  input  logic       rr,
  input  lock_t      lock,
  output logic       sel_valid,
  output logic       sel
);

  always_comb begin
    sel_valid = 1'b0;
    sel       = rr;
    case (lock)
      LK_0: begin
        sel       = 1'b0;
        sel_valid = eligible[0];
      end
      LK_1: begin
        sel       = 1'b1;
        sel_valid = eligible[1];
      end
      default: begin
        if (eligible[rr]) begin
          sel       = rr;
          sel_valid = 1'b1;
        end else if (eligible[~rr]) begin
          sel       = ~rr;
          sel_valid = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/thread_sched.sv
// Issue scheduler: picks one thread's instruction per cycle, keeps pre-prefixes
// atomic with their successor, and tracks per-thread retirement and global halt.
module thread_sched
  import sik_pkg::*;
#(
  parameter int unsigned WIDTH = SIK_WIDTH,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid0,
  input  logic             fetch_valid1,
  input  logic [WIDTH-1:0] fetch_ir0,
  input  logic [WIDTH-1:0] fetch_ir1,
  input  logic             halt_req0,
  input  logic             halt_req1,
  input  logic             stall,
  output logic             fetch_ack0,
  output logic             fetch_ack1,
  output logic             issue_valid,
  output logic             issue_tid,
  output logic [WIDTH-1:0] issue_ir,
  output logic [1:0]       thread_halted,
  output logic             halt,
  output logic [CNTW-1:0]  issue_count
);

  logic             rr;
  lock_t            lock;
  logic [1:0]       eligible;
  logic             sel_valid;
  logic             sel;
  logic [WIDTH-1:0] sel_ir;
  logic             sel_pre;
  logic             take;

  assign eligible[0] = fetch_valid0 & ~thread_halted[0] & ~halt_req0;
  assign eligible[1] = fetch_valid1 & ~thread_halted[1] & ~halt_req1;

  rr_pick2 u_pick (
    .eligible  (eligible),
    .rr        (rr),
    .lock      (lock),
    .sel_valid (sel_valid),
    .sel       (sel)
  );

  assign sel_ir  = sel ? fetch_ir1 : fetch_ir0;
  assign sel_pre = (sel_ir[15:12] == OP_PRE);
  assign take    = ~reset & ~stall & sel_valid;

  assign fetch_ack0 = take & ~sel;
  assign fetch_ack1 = take &  sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_tid     <= 1'b0;
      issue_ir      <= WIDTH'(NOOP_IR);
      thread_halted <= '0;
      halt          <= 1'b0;
      issue_count   <= '0;
      rr            <= 1'b0;
      lock          <= LK_NONE;
    end else begin
      thread_halted <= thread_halted | {halt_req1, halt_req0};
      halt          <= halt | (&thread_halted);

      if (!stall) begin
        if (sel_valid) begin
          issue_valid <= 1'b1;
          issue_tid   <= sel;
          issue_ir    <= sel_ir;
          issue_count <= issue_count + CNTW'(1);
          rr          <= ~sel;
          lock        <= sel_pre ? (sel ? LK_1 : LK_0) : LK_NONE;
        end else begin
          issue_valid <= 1'b0;
          issue_ir    <= WIDTH'(NOOP_IR);
        end
      end

      // Retiring the locked thread releases the lock even under stall, since
      // that thread can never issue the instruction the lock is waiting for.
      if ((lock == LK_0 && halt_req0) || (lock == LK_1 && halt_req1))
        lock <= LK_NONE;
    end
  end

endmodule

// File: doc/thread_sched.md
# thread_sched

Issue scheduler for the two-thread pipelined stack processor. It sits between the two per-thread fetch slots and the shared decode/ALU stage. Each cycle it picks at most one thread's instruction, fairly and round-robin, and registers it into the issue slot. It keeps a `pre` prefix atomic with the instruction that follows it, retires threads that execute `sys`, and raises the global `halt` once both threads are retired.

## Interface
Parameters:
- `WIDTH`, 16: instruction word width.
- `CNTW`, 16: issue counter width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `fetch_valid0`, `fetch_valid1` in 1: thread 0/1 fetch slot holds an instruction.
- `fetch_ir0`, `fetch_ir1` in `WIDTH`: thread 0/1 instruction word.
- `halt_req0`, `halt_req1` in 1: single-cycle pulse from execute; thread executed `sys`.
- `stall` in 1: downstream hazard; freeze the issue slot.
- `fetch_ack0`, `fetch_ack1` out 1: combinational; that thread's slot is consumed at this edge.
- `issue_valid` out 1: issue slot holds a real instruction.
- `issue_tid` out 1: owning thread of the issue slot.
- `issue_ir` out `WIDTH`: issued instruction word.
- `thread_halted` out 2: bit *t* is set once thread *t* has retired.
- `halt` out 1: both threads retired; sticky until `reset`.
- `issue_count` out `CNTW`: number of instructions issued.

## Operation
Eligibility and selection:
- Thread *t* is eligible when `fetch_valid_t` is high, `!thread_halted[t]`, and `!halt_req_t`. A halt request masks the thread in the same cycle.
- Round-robin pointer `rr` names the preferred thread. If the preferred thread is eligible it is selected; otherwise the other thread is selected if eligible; otherwise nothing is selected.
- After an issue, `rr` is set to the opposite of the issued thread.

Prefix lock (state NONE / LOCK0 / LOCK1):
- When the issued instruction has `[15:12]==4'hF` (`pre`), the lock moves to LOCK*t* for the issuing thread *t*.
- While locked to *t*, only thread *t* may be selected. If thread *t* is not eligible, the scheduler inserts a bubble and does not switch threads.
- Issuing any non-`pre` instruction from thread *t* returns the lock to NONE.
- A `halt_req_t` while locked to *t* returns the lock to NONE.

Issue update, on each edge with `!stall`:
- Something selected: `issue_valid`<=1, `issue_tid`<=sel, `issue_ir`<=`fetch_ir_sel`, `issue_count`++ (wraps modulo 2^`CNTW`), and `fetch_ack_sel`=1 during that cycle.
- Nothing selected: `issue_valid`<=0, `issue_ir`<=`NOOP_IR`, and `issue_tid` holds.

Stall (`stall`=1):
- Issue registers, `rr`, the lock state and `issue_count` all hold.
- Both `fetch_ack` outputs are 0.
- `halt_req` pulses are still recorded.

Halt tracking:
- `halt_req_t` sets `thread_halted[t]` at the next edge, regardless of `stall`.
- `halt`<=1 on the edge after both bits of `thread_halted` are set.

## Timing
- Reset values: `issue_valid`=0, `issue_tid`=0, `issue_ir`=`NOOP_IR`, `thread_halted`=0, `halt`=0, `issue_count`=0, `rr`=0, lock=NONE. Both `fetch_ack` outputs are 0 while `reset` is high.
- Issue latency: an instruction presented in cycle N appears in the issue slot in cycle N+1, with its ack high in cycle N.
- Throughput: at most one issue per cycle. With both threads continuously eligible and no `pre`, issues strictly alternate 0,1,0,1…
- Simultaneous halt requests: both bits set at the same edge; `halt` rises one cycle later.
- `halt` high does not stop `stall`/bubble behaviour. No further issues occur, since no thread is eligible.
- Reset asserted mid-lock or mid-stall aborts everything to the reset values; the thread in flight is not acknowledged.

## Structure
- Shared package `sik_pkg`:
  - opcode constant `OP_PRE`=4'hF
  - `NOOP_IR`=16'h003F
  - lock-state encoding
  - `WIDTH` default
- One natural sub-module: `rr_pick2`, a combinational 2-way round-robin picker with a lock input. Inputs: `eligible[1:0]`, `rr`, lock. Outputs: `sel_valid`, `sel`.
- All remaining logic is flat in `thread_sched`.

## Test plan
- Both threads valid, ir0=16'h1001, ir1=16'h8005, 6 cycles -> `issue_tid` sequence 0,1,0,1,0,1; `issue_count`=6; acks alternate.
- Thread 0 issues `pre` 16'hF003 while thread 1 is valid -> next issue is thread 0. If `fetch_valid0` is low for 2 cycles, the bench sees 2 bubbles (`issue_valid`=0, `issue_ir`=16'h003F) with no thread-1 issue, and thread 1 issues only after thread 0's next instruction.
- `stall` held 3 cycles mid-stream -> `issue_ir`/`issue_tid`/`issue_count` unchanged and both acks 0. On release, the issue sequence resumes with the thread after the last issued one.
- `halt_req1` pulse in the same cycle thread 1 would win -> thread 0 issues instead, `thread_halted`=2'b10, and thread 1 is never issued again.
- `halt_req0` then `halt_req1` three cycles apart -> `halt` rises exactly one cycle after the second pulse is registered and stays high.
- Assert `reset` asynchronously mid-cycle while locked with `issue_count`=5 -> outputs take their reset values immediately, without waiting for a clock edge.
